// File: rtl/whack_judge.sv
// ============================================================================
// Module   : whack_judge
// Purpose  : Judges keypad whacks against raised moles, keeps BCD score and
//            miss count, and enforces a post-whack lockout window.
//            Optional macro WHACK_MISS_PENALTY_EN: each miss also decrements
//            the score (floored at 00).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module whack_judge #(
    parameter logic [23:0] LOCKOUT_CYCLES = 24'd5_000_000,
    parameter logic [7:0]  SCORE_MAX      = 8'h99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_key,
    input  logic [3:0] key,
    input  logic [8:0] mole_mask,
    input  logic       round_active,
    output logic       hit,
    output logic       miss,
    output logic       whack_valid,
    output logic [3:0] whack_pos,
    output logic [7:0] score,
    output logic [3:0] miss_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        LOCKOUT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        valid_key_q, valid_key_d;
    logic [23:0] cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic [3:0]  pos_q, pos_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic        w_key_event;

    // Saturating BCD increment; the 99 guard keeps digits legal for any SCORE_MAX.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if ((v >= SCORE_MAX) || (v == 8'h99)) begin
            r = v;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

`ifdef WHACK_MISS_PENALTY_EN
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction
`endif

    assign w_key_event = valid_key & ~valid_key_q;

    always_comb begin
        state_d     = state_q;
        valid_key_d = valid_key;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        pos_d       = pos_q;
        score_d     = score_q;
        miss_cnt_d  = miss_cnt_q;

        if (!round_active) begin
            // Counters hold their values so the final result stays on display.
            state_d = IDLE;
            cnt_d   = 24'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ARMED;
                    score_d    = 8'h00;
                    miss_cnt_d = 4'd0;
                end
                ARMED: begin
                    if (w_key_event && (key <= 4'd8)) begin
                        state_d = LOCKOUT;
                        cnt_d   = LOCKOUT_CYCLES - 24'd1;
                        if (mole_mask[key]) begin
                            hit_d   = 1'b1;
                            pos_d   = key;
                            score_d = bcd_inc(score_q);
                        end else begin
                            miss_d = 1'b1;
                            if (miss_cnt_q != 4'd15) begin
                                miss_cnt_d = miss_cnt_q + 4'd1;
                            end
`ifdef WHACK_MISS_PENALTY_EN
                            score_d = bcd_dec(score_q);
`endif
                        end
                    end
                end
                LOCKOUT: begin
                    if (cnt_q == 24'd0) begin
                        state_d = ARMED;
                    end else begin
                        cnt_d = cnt_q - 24'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_key_q <= 1'b0;
            cnt_q       <= 24'd0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            pos_q       <= 4'd0;
            score_q     <= 8'h00;
            miss_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            valid_key_q <= valid_key_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            pos_q       <= pos_d;
            score_q     <= score_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign hit         = hit_q;
    assign miss        = miss_q;
    assign whack_valid = hit_q;
    assign whack_pos   = pos_q;
    assign score       = score_q;
    assign miss_count  = miss_cnt_q;
    assign busy        = (state_q == LOCKOUT);

endmodule

`default_nettype wire

// File: tb/tb_whack_judge.sv
// ============================================================================
// Module   : tb_whack_judge
// Purpose  : Self-checking bench for whack_judge (table vectors plus directed
//            multi-cycle sequences), with LOCKOUT_CYCLES set to 10.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_whack_judge;

`ifdef WHACK_MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_key = 1'b0;
    logic [3:0] key = 4'd0;
    logic [8:0] mole_mask = 9'h000;
    logic       round_active = 1'b0;
    logic       hit, miss, whack_valid, busy;
    logic [3:0] whack_pos, miss_count;
    logic [7:0] score;

    int n_vec = 0;
    int n_err = 0;
    int guard;

    typedef struct {
        logic [3:0] k;
        logic [8:0] m;
        logic       h;
        logic       mi;
        logic [3:0] pos;
        logic [7:0] s0;   // score without miss penalty
        logic [7:0] s1;   // score with miss penalty
        logic [3:0] mc;
        logic       b;
    } vec_t;

    vec_t tbl [8];

    whack_judge #(
        .LOCKOUT_CYCLES (24'd10),
        .SCORE_MAX      (8'h99)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_key    (valid_key),
        .key          (key),
        .mole_mask    (mole_mask),
        .round_active (round_active),
        .hit          (hit),
        .miss         (miss),
        .whack_valid  (whack_valid),
        .whack_pos    (whack_pos),
        .score        (score),
        .miss_count   (miss_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] outs();
        return {hit, miss, whack_valid, whack_pos, score, miss_count, busy};
    endfunction

    function automatic logic [19:0] expv(input logic h, input logic mi, input logic [3:0] pos,
                                         input logic [7:0] sc, input logic [3:0] mc, input logic b);
        return {h, mi, h, pos, sc, mc, b};
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input logic [8:0] m);
        valid_key = 1'b1;
        key       = k;
        mole_mask = m;
        tick();
    endtask

    task automatic release_and_wait(input string name);
        valid_key = 1'b0;
        tick();
        guard = 0;
        while (busy && guard < 30) begin
            tick();
            guard++;
        end
        check(name, {19'd0, busy}, 20'd0);
    endtask

    task automatic new_round();
        round_active = 1'b0;
        valid_key    = 1'b0;
        tick();
        round_active = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0] = '{4'd5,  9'h001, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 4'd1, 1'b1};
        tbl[1] = '{4'd4,  9'h010, 1'b1, 1'b0, 4'd4, 8'h01, 8'h01, 4'd1, 1'b1};
        tbl[2] = '{4'd12, 9'h1FF, 1'b0, 1'b0, 4'd4, 8'h01, 8'h01, 4'd1, 1'b0};
        tbl[3] = '{4'd0,  9'h001, 1'b1, 1'b0, 4'd0, 8'h02, 8'h02, 4'd1, 1'b1};
        tbl[4] = '{4'd8,  9'h100, 1'b1, 1'b0, 4'd8, 8'h03, 8'h03, 4'd1, 1'b1};
        tbl[5] = '{4'd3,  9'h1F7, 1'b0, 1'b1, 4'd8, 8'h03, 8'h02, 4'd2, 1'b1};
        tbl[6] = '{4'd9,  9'h1FF, 1'b0, 1'b0, 4'd8, 8'h03, 8'h02, 4'd2, 1'b0};
        tbl[7] = '{4'd7,  9'h080, 1'b1, 1'b0, 4'd7, 8'h04, 8'h03, 4'd2, 1'b1};

        // Reset state
        tick();
        tick();
        check("reset_state", outs(), 20'd0);
        reset = 1'b0;
        round_active = 1'b1;
        tick();
        check("round_start", outs(), 20'd0);

        for (int i = 0; i < 8; i++) begin
            press(tbl[i].k, tbl[i].m);
            check($sformatf("tbl%0d", i), outs(),
                  expv(tbl[i].h, tbl[i].mi, tbl[i].pos, PEN ? tbl[i].s1 : tbl[i].s0,
                       tbl[i].mc, tbl[i].b));
            valid_key = 1'b0;
            tick();
            check($sformatf("tbl%0d_pulse_end", i), {18'd0, hit, miss}, 20'd0);
            release_and_wait($sformatf("tbl%0d_lockout_end", i));
        end

        // Lockout: ignored presses, held key across lockout end, then a fresh press
        new_round();
        press(4'd4, 9'h010);
        check("lk_first", outs(), expv(1'b1, 1'b0, 4'd4, 8'h01, 4'd0, 1'b1));
        valid_key = 1'b0;
        tick();
        tick();
        valid_key = 1'b1;
        guard = 0;
        do begin
            tick();
            check("lk_quiet", {18'd0, hit, miss}, 20'd0);
            guard++;
        end while (busy && guard < 30);
        check("lk_busy_end", {19'd0, busy}, 20'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lk_held", {17'd0, hit, miss, busy}, 20'd0);
        end
        valid_key = 1'b0;
        tick();
        press(4'd2, 9'h004);
        check("lk_rejudged", outs(), expv(1'b1, 1'b0, 4'd2, 8'h02, 4'd0, 1'b1));
        release_and_wait("lk_rejudged_end");

        // Score carries and saturation
        new_round();
        for (int i = 1; i <= 101; i++) begin
            press(4'd4, 9'h010);
            check($sformatf("score_hit%0d", i), {11'd0, hit, score},
                  {11'd0, 1'b1, to_bcd(i > 99 ? 99 : i)});
            release_and_wait("score_lockout_end");
        end

        // Miss count saturation
        new_round();
        for (int i = 1; i <= 17; i++) begin
            press(4'd5, 9'h001);
            check($sformatf("miss%0d", i), outs(),
                  expv(1'b0, 1'b1, 4'd4, 8'h00, 4'(i > 15 ? 15 : i), 1'b1));
            release_and_wait("miss_lockout_end");
        end

        // Round ends on a key edge; display freezes; restart clears score
        new_round();
        press(4'd4, 9'h010);
        check("rnd_hit", outs(), expv(1'b1, 1'b0, 4'd4, 8'h01, 4'd0, 1'b1));
        release_and_wait("rnd_lockout_end");
        round_active = 1'b0;
        press(4'd4, 9'h010);
        check("rnd_drop_edge", outs(), expv(1'b0, 1'b0, 4'd4, 8'h01, 4'd0, 1'b0));
        valid_key = 1'b0;
        tick();
        press(4'd4, 9'h010);
        check("rnd_idle_press", outs(), expv(1'b0, 1'b0, 4'd4, 8'h01, 4'd0, 1'b0));
        valid_key = 1'b0;
        round_active = 1'b1;
        tick();
        check("rnd_restart", outs(), expv(1'b0, 1'b0, 4'd4, 8'h00, 4'd0, 1'b0));

        // Reset mid-lockout, then ignored key 12 and a judged press
        press(4'd4, 9'h010);
        check("rst_hit", outs(), expv(1'b1, 1'b0, 4'd4, 8'h01, 4'd0, 1'b1));
        valid_key = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        press(4'd5, 9'h001);
        check("rst_mid_lockout", outs(), 20'd0);
        reset = 1'b0;
        valid_key = 1'b0;
        tick();
        tick();
        press(4'd12, 9'h1FF);
        check("rst_key12", outs(), 20'd0);
        valid_key = 1'b0;
        tick();
        press(4'd4, 9'h010);
        check("rst_armed_hit", outs(), expv(1'b1, 1'b0, 4'd4, 8'h01, 4'd0, 1'b1));
        release_and_wait("rst_lockout_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
